// File: rtl/blinker_pkg.sv
// Shared definitions for the switch conditioning path: debounce FSM states
// and synchronizer depth.
package blinker_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } debounce_state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: two-flop synchronizer feeding a STABLE/PENDING debounce
// FSM whose counter tracks how long the synced level has disagreed.
module switch_debounce
  import blinker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_synced,
  output logic o_debounced
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W:0] TARGET = (CNT_W + 1)'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W:0] ONE    = (CNT_W + 1)'(1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("switch_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  debounce_state_e        state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   debounced_q, debounced_d;
  logic [CNT_W:0]         count_inc;
  logic                   synced;
  logic                   count_done;

  assign synced      = sync_q[SYNC_STAGES-1];
  assign o_synced    = synced;
  assign o_debounced = debounced_q;

  // count_q holds the disagreeing edges already seen; the new level is
  // accepted on the edge that brings that tally up to DEBOUNCE_CYCLES.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], i_raw};
    count_inc   = {1'b0, count_q} + ONE;
    count_done  = (count_inc == TARGET);
    state_d     = state_q;
    count_d     = count_q;
    debounced_d = debounced_q;
    case (state_q)
      STABLE: begin
        if (synced != debounced_q) begin
          if (count_done) begin
            debounced_d = ~debounced_q;
            count_d     = '0;
          end else begin
            state_d = PENDING;
            count_d = count_inc[CNT_W-1:0];
          end
        end
      end
      PENDING: begin
        if (synced == debounced_q) begin
          state_d = STABLE;
          count_d = '0;
        end else if (count_done) begin
          debounced_d = ~debounced_q;
          count_d     = '0;
          state_d     = STABLE;
        end else begin
          count_d = count_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_d = STABLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_q      <= '0;
      state_q     <= STABLE;
      count_q     <= '0;
      debounced_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      count_q     <= count_d;
      debounced_q <= debounced_d;
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Conditions two bouncing switches and presents them as an atomic pair, with
// a one-cycle pulse after each pair update.
module switch_conditioner
  import blinker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_switch_1_raw,
  input  logic i_switch_2_raw,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_changed
);

  logic synced_1, synced_2;
  logic debounced_1, debounced_2;
  logic switch_1_q, switch_1_d;
  logic switch_2_q, switch_2_d;
  logic changed_q, changed_d;
  logic pair_load;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce_1 (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_raw      (i_switch_1_raw),
    .o_synced   (synced_1),
    .o_debounced(debounced_1)
  );

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce_2 (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_raw      (i_switch_2_raw),
    .o_synced   (synced_2),
    .o_debounced(debounced_2)
  );

  // Only publish when neither channel is mid-settle, so a staggered press
  // never shows up as an intermediate pair.
  always_comb begin
    pair_load  = (synced_1 == debounced_1) && (synced_2 == debounced_2) &&
                 ({debounced_1, debounced_2} != {switch_1_q, switch_2_q});
    switch_1_d = switch_1_q;
    switch_2_d = switch_2_q;
    changed_d  = pair_load;
    if (pair_load) begin
      switch_1_d = debounced_1;
      switch_2_d = debounced_2;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      switch_1_q <= 1'b0;
      switch_2_q <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      switch_1_q <= switch_1_d;
      switch_2_q <= switch_2_d;
      changed_q  <= changed_d;
    end
  end

  assign o_switch_1 = switch_1_q;
  assign o_switch_2 = switch_2_q;
  assign o_changed  = changed_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner: one instance with DEBOUNCE_CYCLES=4
// and one with DEBOUNCE_CYCLES=1.
module tb_switch_conditioner;

  logic clk;
  logic rst;
  logic s1_raw, s2_raw;
  logic o1, o2, ch;
  logic q1_raw, q2_raw;
  logic p1, p2, pch;

  int checks;
  int failures;
  int pulses;

  switch_conditioner #(.DEBOUNCE_CYCLES(4)) dut4 (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_switch_1_raw(s1_raw),
    .i_switch_2_raw(s2_raw),
    .o_switch_1    (o1),
    .o_switch_2    (o2),
    .o_changed     (ch)
  );

  switch_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_switch_1_raw(q1_raw),
    .i_switch_2_raw(q2_raw),
    .o_switch_1    (p1),
    .o_switch_2    (p2),
    .o_changed     (pch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic e;
    rst = 1'b1; s1_raw = 1'b1; s2_raw = 1'b1; q1_raw = 1'b0; q2_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({o1, o2, ch} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b%b%b want=000", i, o1, o2, ch);
      end
      checks++;
      if ({p1, p2, pch} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold_d1 cyc=%0d got=%b%b%b want=000", i, p1, p2, pch);
      end
    end
    rst = 1'b0;
    pulses = 0;
    for (int j = 1; j <= 8; j++) begin
      step();
      e = (j >= 7);
      if (ch === 1'b1) pulses++;
      checks++;
      if ({o1, o2} !== {e, e}) begin
        failures++;
        $display("FAIL reset_release_out r+%0d got=%b%b want=%b%b", j, o1, o2, e, e);
      end
      checks++;
      if (ch !== (j == 7)) begin
        failures++;
        $display("FAIL reset_release_chg r+%0d got=%b want=%b", j, ch, (j == 7));
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL reset_release_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_reset_clears();
    rst = 1'b1; s1_raw = 1'b0; s2_raw = 1'b0;
    step();
    checks++;
    if ({o1, o2, ch} !== 3'b000) begin
      failures++;
      $display("FAIL reset_clears got=%b%b%b want=000", o1, o2, ch);
    end
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      checks++;
      if ({o1, o2, ch} !== 3'b000) begin
        failures++;
        $display("FAIL idle_after_reset c%0d got=%b%b%b want=000", j, o1, o2, ch);
      end
    end
  endtask

  task automatic test_single(input logic lvl);
    logic e;
    s1_raw = lvl;
    for (int j = 1; j <= 8; j++) begin
      step();
      e = (j >= 7) ? lvl : ~lvl;
      checks++;
      if ({o1, o2, ch} !== {e, 1'b0, (j == 7)}) begin
        failures++;
        $display("FAIL single_%0d k+%0d got=%b%b%b want=%b0%b", lvl, j - 1,
                 o1, o2, ch, e, (j == 7));
      end
    end
  endtask

  task automatic test_bounce();
    for (int w = 2; w <= 3; w++) begin
      s1_raw = 1'b1;
      repeat (w) step();
      s1_raw = 1'b0;
      for (int j = 0; j < 10; j++) begin
        step();
        checks++;
        if ({o1, ch} !== 2'b00) begin
          failures++;
          $display("FAIL bounce_w%0d c%0d got=%b%b want=00", w, j, o1, ch);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    pulses = 0;
    s1_raw = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      step();
      if (j == 2) s2_raw = 1'b1;
      e = (j >= 9);
      if (ch === 1'b1) pulses++;
      checks++;
      if ({o1, o2, ch} !== {e, e, (j == 9)}) begin
        failures++;
        $display("FAIL staggered k+%0d got=%b%b%b want=%b%b%b", j - 1,
                 o1, o2, ch, e, e, (j == 9));
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL staggered_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    rst = 1'b1; s1_raw = 1'b0; s2_raw = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    s1_raw = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if ({o1, o2, ch} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset got=%b%b%b want=000", o1, o2, ch);
    end
    rst = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      e = (j >= 7);
      checks++;
      if ({o1, o2, ch} !== {e, 1'b0, (j == 7)}) begin
        failures++;
        $display("FAIL mid_reset_restart r+%0d got=%b%b%b want=%b0%b", j,
                 o1, o2, ch, e, (j == 7));
      end
    end
  endtask

  task automatic test_dc1();
    logic e;
    q2_raw = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      e = (j >= 4);
      checks++;
      if ({p1, p2, pch} !== {1'b0, e, (j == 4)}) begin
        failures++;
        $display("FAIL dc1_rise k+%0d got=%b%b%b want=0%b%b", j - 1, p1, p2, pch, e, (j == 4));
      end
    end
    q2_raw = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      e = (j < 4);
      checks++;
      if ({p1, p2, pch} !== {1'b0, e, (j == 4)}) begin
        failures++;
        $display("FAIL dc1_fall k+%0d got=%b%b%b want=0%b%b", j - 1, p1, p2, pch, e, (j == 4));
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; pulses = 0;
    rst = 1'b0; s1_raw = 1'b0; s2_raw = 1'b0; q1_raw = 1'b0; q2_raw = 1'b0;
    test_reset();
    test_reset_clears();
    test_single(1'b1);
    test_single(1'b0);
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_dc1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, number of consecutive clocks a synchronized switch level must differ from its debounced value before the debounced value is accepted; legal range >= 1.
REQ-002 i_clock  input  1  single clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-high.
REQ-004 i_switch_1_raw  input  1  asynchronous, bouncing mechanical switch 1.
REQ-005 i_switch_2_raw  input  1  asynchronous, bouncing mechanical switch 2.
REQ-006 o_switch_1  output  1  conditioned switch 1; drives the blinker's i_switch_1.
REQ-007 o_switch_2  output  1  conditioned switch 2; drives the blinker's i_switch_2.
REQ-008 o_changed  output  1  one-cycle pulse; high in the cycle after {o_switch_1,o_switch_2} updates.

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer; only the second flop output (synced level) is used downstream.
REQ-010 Per channel, a debounce FSM SHALL have two states: STABLE (synced == debounced, counter 0) and PENDING (synced != debounced, counter running).
REQ-011 STABLE -> PENDING when synced != debounced; counter loads 1.
REQ-012 In PENDING, synced == debounced SHALL return to STABLE with counter cleared and debounced unchanged (bounce rejected).
REQ-013 In PENDING, synced != debounced with counter == DEBOUNCE_CYCLES SHALL invert debounced, clear the counter, and enter STABLE; otherwise the counter increments.
REQ-014 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits; the counter never exceeds DEBOUNCE_CYCLES and never wraps.
REQ-015 Channel latency: if edge k is the first edge to sample a new raw level held steady, debounced updates on edge k+1+DEBOUNCE_CYCLES.
REQ-016 Pair stage: {o_switch_1,o_switch_2} SHALL load {debounced_1,debounced_2} only on an edge where both channels have synced == debounced and the pair differs from the current outputs; otherwise they hold.
REQ-017 Consequence: outputs never present an intermediate pair while the other channel is still settling; clean single-switch change appears at edge k+2+DEBOUNCE_CYCLES.
REQ-018 o_changed SHALL be high for exactly the one cycle following a pair update; simultaneous change of both switches produces one pulse, not two.
REQ-019 A raw level reverting before the count completes SHALL produce no output change and no pulse.

Reset
REQ-020 While i_reset is high at an edge: synchronizer flops, debounced values, counters, o_switch_1, o_switch_2 and o_changed SHALL be 0, and FSMs SHALL be STABLE.
REQ-021 Reset asserted mid-debounce SHALL discard the pending count; after release the debounce restarts from the first edge sampling raw level.
REQ-022 Raw inputs high during reset SHALL be treated as a change after release: outputs go to 1 after the full latency and o_changed pulses once.

Structure
REQ-023 FSM state encodings (STABLE, PENDING) and the synchronizer depth constant (2) SHALL live in the shared package blinker_pkg.
REQ-024 One sub-module switch_debounce (synchronizer + FSM + counter, one channel, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice; the pair stage and o_changed reside in switch_conditioner.
REQ-025 Elaboration SHALL fail if DEBOUNCE_CYCLES < 1.

Verification (DEBOUNCE_CYCLES = 4 unless stated)
REQ-026 Reset 3 cycles with both raw = 1, release at edge r -> outputs 0 during reset; both outputs rise together at edge r+7; one o_changed pulse.
REQ-027 Raw switch_1 0->1 steady, first sampled edge k -> o_switch_1 rises at edge k+6, o_switch_2 unchanged, o_changed high for the cycle after k+6.
REQ-028 Raw switch_1 pulses high 2 cycles then low (bounce) -> o_switch_1 stays 0, o_changed never asserts.
REQ-029 Switch_1 rises at edge k, switch_2 rises at edge k+2 -> no update at k+6; both outputs rise at edge k+8; exactly one o_changed pulse.
REQ-030 Switch_1 rises at edge k, i_reset high for one edge at k+3, raw stays 1 -> outputs 0 through reset; o_switch_1 rises at edge r+7 after release edge r.
REQ-031 DEBOUNCE_CYCLES = 1, switch_2 falls after being 1 -> o_switch_2 falls at edge k+3; counter never exceeds 1.
